// File: rtl/tone_decoder.sv
// Tone receive path: measures rising-edge-to-rising-edge period of the speaker line,
// classifies it against the four key tones and reports a key after CONFIRM agreeing periods.
module tone_decoder #(
  parameter int HALF1   = 25000,
  parameter int HALF2   = 12500,
  parameter int HALF3   = 6250,
  parameter int HALF4   = 3125,
  parameter int TOL     = 64,
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 65536,
  parameter int CNT_W   = 17
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tone,
  output logic [3:0] o_key,
  output logic       o_valid,
  output logic       o_change
);
  localparam int MW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t            state, state_n;
  logic [2:0]        sync;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        cand, cand_n, cls;
  logic [MW-1:0]     match, match_n;
  logic [3:0]        key_n;
  logic              valid_n, change_n, tone_edge, timed_out;

  function automatic logic in_band(input logic [CNT_W-1:0] p, input int half);
    int pi;
    pi = int'(p);
    return (pi >= 2 * half - TOL) && (pi <= 2 * half + TOL);
  endfunction

  // Checked highest key first so that the lowest matching key wins on overlap.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
    logic [2:0] c;
    c = 3'd0;
    if (in_band(p, HALF4)) c = 3'd4;
    if (in_band(p, HALF3)) c = 3'd3;
    if (in_band(p, HALF2)) c = 3'd2;
    if (in_band(p, HALF1)) c = 3'd1;
    return c;
  endfunction

  function automatic logic [3:0] onehot(input logic [2:0] c);
    case (c)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0100;
      3'd4:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  assign tone_edge = sync[1] & ~sync[2];
  assign timed_out = (cnt == CNT_W'(TIMEOUT));
  assign cls       = classify(cnt);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[1:0], i_tone};
      if (tone_edge)       cnt <= CNT_W'(1);
      else if (!timed_out) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    match_n  = match;
    key_n    = o_key;
    valid_n  = o_valid;
    change_n = 1'b0;
    if (state == IDLE) begin
      if (tone_edge) state_n = MEASURE;
    end else if (tone_edge) begin
      if (cls == 3'd0) begin
        cand_n  = 3'd0;
        match_n = '0;
        state_n = MEASURE;
        if (o_valid) begin
          key_n    = 4'b0000;
          valid_n  = 1'b0;
          change_n = 1'b1;
        end
      end else begin
        if (cls == cand) begin
          if (match != MW'(CONFIRM)) match_n = match + 1'b1;
        end else begin
          cand_n  = cls;
          match_n = MW'(1);
        end
        // A new key replaces the old one directly, without passing through zero.
        if (match_n == MW'(CONFIRM) && o_key != onehot(cand_n)) begin
          key_n    = onehot(cand_n);
          valid_n  = 1'b1;
          change_n = 1'b1;
          state_n  = LOCKED;
        end
      end
    end else if (timed_out) begin
      state_n = IDLE;
      cand_n  = 3'd0;
      match_n = '0;
      if (o_valid) begin
        key_n    = 4'b0000;
        valid_n  = 1'b0;
        change_n = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      cand     <= '0;
      match    <= '0;
      o_key    <= '0;
      o_valid  <= 1'b0;
      o_change <= 1'b0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      match    <= match_n;
      o_key    <= key_n;
      o_valid  <= valid_n;
      o_change <= change_n;
    end
  end
endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder using scaled-down tone periods (800/400/200/100, TOL 8).
module tb_tone_decoder;
  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_tone = 1'b0;
  logic [3:0] o_key;
  logic       o_valid;
  logic       o_change;

  int errors = 0;
  int checks = 0;
  int chg_cnt = 0;
  int vlow_cnt = 0;
  bit watch_valid = 1'b0;

  tone_decoder #(
    .HALF1(400), .HALF2(200), .HALF3(100), .HALF4(50),
    .TOL(8), .CONFIRM(2), .TIMEOUT(1024), .CNT_W(11)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tone(i_tone),
    .o_key(o_key), .o_valid(o_valid), .o_change(o_change)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_change) chg_cnt++;
    if (watch_valid && !o_valid) vlow_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One tone period: h cycles high then l cycles low, starting at a negedge.
  task automatic tone(input int h, input int l);
    i_tone = 1'b1;
    repeat (h) @(negedge i_clk);
    i_tone = 1'b0;
    repeat (l) @(negedge i_clk);
  endtask

  initial begin
    #1;
    chk("rst_key", 32'(o_key), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_change", 32'(o_change), 32'h0);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (5) @(negedge i_clk);

    // key 1 lock from silence
    tone(400, 400); chk("k1_edge1", 32'(o_key), 32'h0);
    tone(400, 400); chk("k1_edge2", 32'(o_key), 32'h0);
    tone(400, 400); chk("k1_lock", 32'(o_key), 32'h1);
    chk("k1_valid", 32'(o_valid), 32'h1);
    chk("k1_chg", 32'(chg_cnt), 32'd1);
    tone(400, 400); chk("k1_steady", 32'(o_key), 32'h1);
    chk("k1_chg_steady", 32'(chg_cnt), 32'd1);

    // key 2 lock, then switch directly to key 3
    tone(200, 200);
    tone(200, 200); chk("k2_hold", 32'(o_key), 32'h1);
    tone(200, 200); chk("k2_lock", 32'(o_key), 32'h2);
    chk("k2_chg", 32'(chg_cnt), 32'd2);
    watch_valid = 1'b1;
    tone(100, 100); chk("sw_p1", 32'(o_key), 32'h2);
    tone(100, 100); chk("sw_p2", 32'(o_key), 32'h2);
    tone(100, 100); chk("sw_k3", 32'(o_key), 32'h4);
    watch_valid = 1'b0;
    chk("sw_chg", 32'(chg_cnt), 32'd3);
    chk("sw_valid_gap", 32'(vlow_cnt), 32'd0);

    // key 4 lock, tolerance boundary 108 in, 109 out
    tone(50, 50);
    tone(50, 50);
    tone(50, 50); chk("k4_lock", 32'(o_key), 32'h8);
    chk("k4_chg", 32'(chg_cnt), 32'd4);
    tone(54, 54);
    tone(55, 54); chk("tol_in", 32'(o_key), 32'h8);
    tone(50, 50); chk("tol_out_key", 32'(o_key), 32'h0);
    chk("tol_out_valid", 32'(o_valid), 32'h0);
    chk("tol_out_chg", 32'(chg_cnt), 32'd5);
    tone(50, 50); chk("relock_p1", 32'(o_key), 32'h0);
    tone(50, 50); chk("relock_k4", 32'(o_key), 32'h8);
    chk("relock_chg", 32'(chg_cnt), 32'd6);

    // key 1 lock, then silence timeout
    tone(400, 400);
    tone(400, 400);
    tone(400, 400); chk("to_k1", 32'(o_key), 32'h1);
    chk("to_k1_chg", 32'(chg_cnt), 32'd7);
    repeat (200) @(negedge i_clk);
    chk("to_before", 32'(o_key), 32'h1);
    repeat (40) @(negedge i_clk);
    chk("to_key", 32'(o_key), 32'h0);
    chk("to_valid", 32'(o_valid), 32'h0);
    chk("to_chg", 32'(chg_cnt), 32'd8);
    tone(400, 400); chk("to_restart1", 32'(o_key), 32'h0);
    tone(400, 400); chk("to_restart2", 32'(o_key), 32'h0);
    tone(400, 400); chk("to_relock", 32'(o_key), 32'h1);
    chk("to_relock_chg", 32'(chg_cnt), 32'd9);

    // key 3 lock, asynchronous reset mid-period
    tone(100, 100);
    tone(100, 100);
    tone(100, 100); chk("rs_k3", 32'(o_key), 32'h4);
    chk("rs_k3_chg", 32'(chg_cnt), 32'd10);
    i_tone = 1'b1;
    repeat (50) @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    chk("rs_async_key", 32'(o_key), 32'h0);
    chk("rs_async_valid", 32'(o_valid), 32'h0);
    i_tone = 1'b0;
    @(negedge i_clk);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    tone(100, 100);
    tone(100, 100); chk("rs_relock_p2", 32'(o_key), 32'h0);
    tone(100, 100); chk("rs_relock", 32'(o_key), 32'h4);
    chk("rs_relock_chg", 32'(chg_cnt), 32'd11);

    // alternating 800/400 periods from a fresh reset never confirm
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      tone(400, 400);
      tone(200, 200);
      chk("alt_valid", 32'(o_valid), 32'h0);
    end
    chk("alt_chg", 32'(chg_cnt), 32'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
